// File: rtl/shift_seq_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg : constants shared by the multicycle shift sequencer.
//   WIDTH / SHW    default data width and shift-amount width (WIDTH = 2**SHW)
//   SHIFT_STAGES   number of fixed-distance stages, one per shamt bit
//   OP_SLL/OP_SRA  operation select encodings
//   ST_*           FSM state encodings (also exported on the debug state bus)
// ---------------------------------------------------------------------------
package shift_pkg;

  localparam int WIDTH        = 32;
  localparam int SHW          = 5;
  localparam int SHIFT_STAGES = SHW;

  localparam logic OP_SLL = 1'b0;
  localparam logic OP_SRA = 1'b1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_RUN  = 2'b01;
  localparam state_t ST_DONE = 2'b10;

endpackage

// File: rtl/shift_seq_if.sv
// ---------------------------------------------------------------------------
// shift_seq_if : start/busy/done handshake bundle between the execute stage
// (master) and the shift sequencer (slave).
//   start    master->slave  request, sampled only while busy is low
//   op       master->slave  0 = SLL, 1 = SRA
//   data_in  master->slave  operand
//   shamt    master->slave  shift amount
//   busy     slave->master  shift in flight; master stalls
//   done     slave->master  one-cycle pulse, result valid
//   result   slave->master  shifted value, held until the next accepted start
//   dbg_state slave->master current FSM state (observation only)
//
// Handshake: a request is accepted on any rising edge where start = 1 and
// busy = 0 (including the done cycle); operands are captured on that edge
// and need not be held afterwards. start while busy = 1 is ignored, never
// queued. done follows a fixed number of edges after acceptance.
// ---------------------------------------------------------------------------
interface shift_seq_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] data_in;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [1:0]       dbg_state;

  modport master (
    output start, op, data_in, shamt,
    input  busy, done, result, dbg_state
  );

  modport slave (
    input  start, op, data_in, shamt,
    output busy, done, result, dbg_state
  );

endinterface

// File: rtl/shift_seq_step.sv
// ---------------------------------------------------------------------------
// shift_step : one combinational fixed-distance barrel stage.
//   data_i    operand
//   enable_i  1 = apply the shift, 0 = pass data_i through
//   dir_i     OP_SLL = left with zero fill, OP_SRA = right with sign fill
//   data_o    stage output
// Parameter DIST is the fixed shift distance (1 .. WIDTH-1).
// ---------------------------------------------------------------------------
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             enable_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] left_w;
  logic [WIDTH-1:0] right_w;

  assign left_w  = {data_i[WIDTH-1-DIST:0], {DIST{1'b0}}};
  // Fill from the current MSB so the sign survives every stage.
  assign right_w = {{DIST{data_i[WIDTH-1]}}, data_i[WIDTH-1:DIST]};

  always_comb begin
    data_o = data_i;
    if (enable_i) begin
      data_o = (dir_i == OP_SRA) ? right_w : left_w;
    end
  end

endmodule

// File: rtl/shift_seq.sv
// ---------------------------------------------------------------------------
// shift_seq : multicycle SLL/SRA sequencer. Applies the 16, 8, 4, 2, 1
// stages one per clock to a working register, gated by the captured shamt.
//   clock   rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     shift_seq_if slave modport (start/op/data_in/shamt in,
//           busy/done/result/dbg_state out)
// Timing: accept edge captures operands, five further edges run the stages,
// the last of them moves to DONE, where done is high for one cycle. Latency
// is the same for every shamt, including zero.
// ---------------------------------------------------------------------------
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = shift_pkg::WIDTH,
  parameter int SHW   = shift_pkg::SHW
) (
  input  logic       clock,
  input  logic       resetn,
  shift_seq_if.slave bus
);

  localparam int STEP_W = $clog2(SHW + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic             op_q,    op_d;
  logic [SHW-1:0]   shamt_q, shamt_d;

  logic [WIDTH-1:0] stage_out [SHW];
  logic [WIDTH-1:0] sel_work;
  logic             accept;

  // Stage k applies distance 2**(SHW-1-k), enabled by shamt bit SHW-1-k.
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_step #(
      .WIDTH (WIDTH),
      .DIST  (1 << (SHW - 1 - k))
    ) u_step (
      .data_i   (work_q),
      .enable_i (shamt_q[SHW-1-k]),
      .dir_i    (op_q),
      .data_o   (stage_out[k])
    );
  end

  always_comb begin
    sel_work = work_q;
    for (int k = 0; k < SHW; k++) begin
      if (step_q == STEP_W'(k)) begin
        sel_work = stage_out[k];
      end
    end
  end

  // A new request is taken whenever the block is not running.
  assign accept = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    step_d  = step_q;
    op_d    = op_q;
    shamt_d = shamt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        work_d = sel_work;
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(SHW - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = accept ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (accept) begin
      work_d  = bus.data_in;
      op_d    = bus.op;
      shamt_d = bus.shamt;
      step_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      step_q  <= '0;
      op_q    <= 1'b0;
      shamt_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      step_q  <= step_d;
      op_q    <= op_d;
      shamt_q <= shamt_d;
    end
  end

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.result    = work_q;
  assign bus.dbg_state = state_q;

endmodule
